// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit with valid/ready on both sides.
// Multiply completes in MUL_LAT cycles; divide uses a restoring divider with a
// one-cycle special-case check, XLEN iterations and a final sign-fixup cycle.
module muldiv_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam int unsigned PW = 2 * XLEN;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_INIT,
        S_DIV,
        S_DIV_SIGN,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;

    logic            accept;
    logic            load_result;
    logic [XLEN-1:0] result_next;
    logic            cnt_clr;
    logic            cnt_inc;
    logic            div_load;
    logic            div_step;

    // Operand decode for both datapaths
    logic            div_signed;
    logic            a_neg;
    logic            b_neg;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            mul_a_signed;
    logic            mul_b_signed;
    logic [PW-1:0]   a_ext;
    logic [PW-1:0]   b_ext;
    logic [PW-1:0]   product;
    logic [XLEN-1:0] mul_res;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] q_fin;
    logic [XLEN-1:0] r_fin;

    assign accept = in_valid && in_ready && !flush;

    // Operand classification, product and divider step logic
    always_comb begin
        div_signed   = !op_q[0];
        a_neg        = a_q[XLEN-1];
        b_neg        = b_q[XLEN-1];
        div_zero     = (b_q == '0);
        div_ovf      = div_signed && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
        mag_a        = (div_signed && a_neg) ? XLEN'(-a_q) : a_q;
        mag_b        = (div_signed && b_neg) ? XLEN'(-b_q) : b_q;
        mul_a_signed = op_q[0] ^ op_q[1];
        mul_b_signed = (op_q[1:0] == 2'b01);
        a_ext        = {{XLEN{mul_a_signed & a_q[XLEN-1]}}, a_q};
        b_ext        = {{XLEN{mul_b_signed & b_q[XLEN-1]}}, b_q};
        product      = PW'(a_ext * b_ext);
        mul_res      = (op_q[1:0] == 2'b00) ? product[XLEN-1:0] : product[PW-1:XLEN];
        rem_sh       = {rem_q, quo_q[XLEN-1]};
        diff         = rem_sh - {1'b0, dvs_q};
        q_fin        = (div_signed && (a_neg ^ b_neg)) ? XLEN'(-quo_q) : quo_q;
        r_fin        = (div_signed && a_neg) ? XLEN'(-rem_q) : rem_q;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control; flush overrides everything
    always_comb begin
        state_next  = state;
        load_result = 1'b0;
        result_next = '0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        div_load    = 1'b0;
        div_step    = 1'b0;
        unique case (state)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (in_valid) begin
                    state_next = op[2] ? S_DIV_INIT : S_MUL;
                end
            end
            S_MUL: begin
                cnt_inc = 1'b1;
                if (cnt == CW'(MUL_LAT - 1)) begin
                    state_next  = S_DONE;
                    load_result = 1'b1;
                    result_next = mul_res;
                end
            end
            S_DIV_INIT: begin
                cnt_clr = 1'b1;
                if (div_zero) begin
                    state_next  = S_DONE;
                    load_result = 1'b1;
                    result_next = op_q[1] ? a_q : '1;
                end else if (div_ovf) begin
                    state_next  = S_DONE;
                    load_result = 1'b1;
                    result_next = op_q[1] ? '0 : a_q;
                end else begin
                    state_next = S_DIV;
                    div_load   = 1'b1;
                end
            end
            S_DIV: begin
                div_step = 1'b1;
                cnt_inc  = 1'b1;
                if (cnt == CW'(XLEN - 1)) begin
                    state_next = S_DIV_SIGN;
                end
            end
            S_DIV_SIGN: begin
                state_next  = S_DONE;
                load_result = 1'b1;
                result_next = op_q[1] ? r_fin : q_fin;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (flush) begin
            state_next  = S_IDLE;
            load_result = 1'b0;
            div_load    = 1'b0;
            div_step    = 1'b0;
        end
    end

    // Registered handshake outputs derived from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (state_next == S_IDLE);
            out_valid <= (state_next == S_DONE);
            busy      <= (state_next != S_IDLE);
        end
    end

    // Operand capture, iteration counter, divider registers and result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cnt    <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            result <= '0;
        end else begin
            if (accept) begin
                op_q <= op;
                a_q  <= a;
                b_q  <= b;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CW'(1);
            end
            if (div_load) begin
                rem_q <= '0;
                quo_q <= mag_a;
                dvs_q <= mag_b;
            end else if (div_step) begin
                rem_q <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], !diff[XLEN]};
            end
            if (load_result) begin
                result <= result_next;
            end
        end
    end

endmodule
